taumin_stabilizer: RTL and testbench

//  Sits between yin and bufferizer. Cleans the raw pitch-period estimate (taumin) stream before it

---
 rtl/taumin_stabilizer.sv | 160 ++++++++++++++++
 tb/tb_taumin_stabilizer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/taumin_stabilizer.sv
// taumin_stabilizer: qualifies raw yin lag estimates before they reach bufferizer.
// Lags outside [TAU_LO, TAU_HI] are rejected. A lag is only forwarded after
// LOCK_COUNT consecutive near estimates. Lock is kept through short bursts of
// bad estimates, so single-window octave jumps never reach the output.
module taumin_stabilizer #(
    parameter int WIDTH      = 11,
    parameter int TAU_LO     = 20,
    parameter int TAU_HI     = 2047,
    parameter int TOL        = 4,
    parameter int LOCK_COUNT = 3,
    parameter int HOLD_MAX   = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] taumin_in,
    input  logic             taumin_valid_in,
    output logic [WIDTH-1:0] taumin_out,
    output logic             taumin_valid_out,
    output logic             locked_out
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int HW = $clog2(HOLD_MAX + 1);

    localparam logic [MW-1:0]  LOCK_N = MW'(LOCK_COUNT);
    localparam logic [HW-1:0]  HOLD_N = HW'(HOLD_MAX);
    localparam logic [WIDTH:0] LO_W   = (WIDTH+1)'(TAU_LO);
    localparam logic [WIDTH:0] HI_W   = (WIDTH+1)'(TAU_HI);
    localparam logic [WIDTH:0] TOL_W  = (WIDTH+1)'(TOL);

    localparam logic [1:0] S_UNLOCKED = 2'd0;
    localparam logic [1:0] S_ACQUIRE  = 2'd1;
    localparam logic [1:0] S_LOCKED   = 2'd2;

    logic [1:0]       state, state_nxt;
    logic [WIDTH-1:0] cand, cand_nxt;
    logic [MW-1:0]    match_cnt, match_nxt, match_inc;
    logic [HW-1:0]    miss_cnt, miss_nxt, miss_inc;
    logic [WIDTH-1:0] out_nxt;
    logic             vld_nxt;
    logic [WIDTH:0]   lo_diff, hi_diff;
    logic             in_range, near_cand, near_out;

    // |a - b| <= TOL using a WIDTH+1-bit signed difference, so the
    // subtraction never wraps around.
    function automatic logic is_near(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] d;
        logic [WIDTH:0] m;
        d = {1'b0, a} - {1'b0, b};
        m = d[WIDTH] ? -d : d;
        return m <= TOL_W;
    endfunction

    // Range test via sign bits of the differences; a TAU_HI at the top of
    // the WIDTH range then needs no special case.
    always_comb begin
        lo_diff   = {1'b0, taumin_in} - LO_W;
        hi_diff   = HI_W - {1'b0, taumin_in};
        in_range  = !lo_diff[WIDTH] && !hi_diff[WIDTH];
        near_cand = is_near(taumin_in, cand);
        near_out  = is_near(taumin_in, taumin_out);
        match_inc = (match_cnt == LOCK_N) ? match_cnt : match_cnt + 1'b1;
        miss_inc  = (miss_cnt == HOLD_N) ? miss_cnt : miss_cnt + 1'b1;
    end

    // Next-state logic. Only a strobe cycle can change anything.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        match_nxt = match_cnt;
        miss_nxt  = miss_cnt;
        out_nxt   = taumin_out;
        vld_nxt   = 1'b0;
        if (taumin_valid_in) begin
            case (state)
                S_UNLOCKED: begin
                    if (in_range) begin
                        cand_nxt  = taumin_in;
                        match_nxt = MW'(1);
                        if (LOCK_COUNT == 1) begin
                            state_nxt = S_LOCKED;
                            out_nxt   = taumin_in;
                            vld_nxt   = 1'b1;
                            miss_nxt  = '0;
                        end else begin
                            state_nxt = S_ACQUIRE;
                        end
                    end
                end
                S_ACQUIRE: begin
                    if (in_range && near_cand) begin
                        cand_nxt  = taumin_in;
                        match_nxt = match_inc;
                        if (match_inc == LOCK_N) begin
                            state_nxt = S_LOCKED;
                            out_nxt   = taumin_in;
                            vld_nxt   = 1'b1;
                            miss_nxt  = '0;
                        end
                    end else if (in_range) begin
                        // Far jump: restart acquisition around the new lag.
                        cand_nxt  = taumin_in;
                        match_nxt = MW'(1);
                    end else begin
                        state_nxt = S_UNLOCKED;
                        match_nxt = '0;
                    end
                end
                S_LOCKED: begin
                    if (in_range && near_out) begin
                        out_nxt  = taumin_in;
                        vld_nxt  = 1'b1;
                        miss_nxt = '0;
                    end else if (miss_inc == HOLD_N) begin
                        // Too many bad estimates; the dropping estimate may
                        // seed a fresh acquisition if it is usable.
                        miss_nxt = '0;
                        if (in_range) begin
                            state_nxt = S_ACQUIRE;
                            cand_nxt  = taumin_in;
                            match_nxt = MW'(1);
                        end else begin
                            state_nxt = S_UNLOCKED;
                            match_nxt = '0;
                        end
                    end else begin
                        miss_nxt = miss_inc;
                    end
                end
                default: begin
                    state_nxt = S_UNLOCKED;
                    match_nxt = '0;
                    miss_nxt  = '0;
                end
            endcase
        end
    end

    // State and output registers; async reset clears everything with no pulse.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state            <= S_UNLOCKED;
            cand             <= '0;
            match_cnt        <= '0;
            miss_cnt         <= '0;
            taumin_out       <= '0;
            taumin_valid_out <= 1'b0;
        end else begin
            state            <= state_nxt;
            cand             <= cand_nxt;
            match_cnt        <= match_nxt;
            miss_cnt         <= miss_nxt;
            taumin_out       <= out_nxt;
            taumin_valid_out <= vld_nxt;
        end
    end

    assign locked_out = (state == S_LOCKED);

endmodule

// File: tb/tb_taumin_stabilizer.sv
// Directed testbench for taumin_stabilizer: acquisition, miss tolerance,
// lock drop, range/tolerance edges and asynchronous reset.
module tb_taumin_stabilizer;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [10:0] taumin_in = '0;
    logic        taumin_valid_in = 1'b0;
    logic [10:0] taumin_out;
    logic        taumin_valid_out;
    logic        locked_out;
    int          errors = 0;
    int          checks = 0;

    taumin_stabilizer dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .taumin_in       (taumin_in),
        .taumin_valid_in (taumin_valid_in),
        .taumin_out      (taumin_out),
        .taumin_valid_out(taumin_valid_out),
        .locked_out      (locked_out)
    );

    always #5 clk_in = ~clk_in;

    // Present one strobe from a negedge; return at the next negedge, where
    // the result of the sampling posedge is visible. Valid stays high so
    // consecutive calls form back-to-back strobes.
    task automatic send(input int t);
        taumin_in       = 11'(t);
        taumin_valid_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic idle();
        taumin_valid_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        taumin_valid_in = 1'b0;
        rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checks++; if (taumin_out !== 11'd0) begin errors++; $display("FAIL rst_out got=%0d exp=0", taumin_out); end
        checks++; if (taumin_valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", taumin_valid_out); end
        checks++; if (locked_out !== 1'b0) begin errors++; $display("FAIL rst_locked got=%0b exp=0", locked_out); end
        rst_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_acquire();
        send(100);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL acq_s1 valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(101);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL acq_s2 valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(99);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd99 || locked_out !== 1'b1) begin errors++; $display("FAIL acq_lock valid=%0b out=%0d locked=%0b exp 1/99/1", taumin_valid_out, taumin_out, locked_out); end
        idle();
        checks++; if (taumin_valid_out !== 1'b0 || taumin_out !== 11'd99) begin errors++; $display("FAIL acq_pulse valid=%0b out=%0d exp 0/99", taumin_valid_out, taumin_out); end
    endtask

    task automatic test_miss_recover();
        send(100);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd100) begin errors++; $display("FAIL mr_100 valid=%0b out=%0d exp 1/100", taumin_valid_out, taumin_out); end
        send(200);
        checks++; if (taumin_valid_out !== 1'b0 || taumin_out !== 11'd100 || locked_out !== 1'b1) begin errors++; $display("FAIL mr_200 valid=%0b out=%0d locked=%0b exp 0/100/1", taumin_valid_out, taumin_out, locked_out); end
        send(100);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd100) begin errors++; $display("FAIL mr_back valid=%0b out=%0d exp 1/100", taumin_valid_out, taumin_out); end
        // Seven misses stay locked; a good estimate then clears the count.
        for (int i = 0; i < 7; i++) begin
            send(5);
            checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b1) begin errors++; $display("FAIL mr_miss%0d valid=%0b locked=%0b exp 0/1", i, taumin_valid_out, locked_out); end
        end
        send(100);
        checks++; if (taumin_valid_out !== 1'b1 || locked_out !== 1'b1) begin errors++; $display("FAIL mr_clear valid=%0b locked=%0b exp 1/1", taumin_valid_out, locked_out); end
        idle();
    endtask

    task automatic test_drop_unlocked();
        for (int i = 0; i < 8; i++) begin
            send(5);
            if (i < 7) begin
                checks++; if (locked_out !== 1'b1 || taumin_valid_out !== 1'b0) begin errors++; $display("FAIL du_hold%0d locked=%0b valid=%0b exp 1/0", i, locked_out, taumin_valid_out); end
            end
        end
        checks++; if (locked_out !== 1'b0 || taumin_valid_out !== 1'b0 || taumin_out !== 11'd100) begin errors++; $display("FAIL du_drop locked=%0b valid=%0b out=%0d exp 0/0/100", locked_out, taumin_valid_out, taumin_out); end
        idle();
    endtask

    task automatic test_restart();
        send(100);
        send(110);
        send(111);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL rs_111 valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(112);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd112 || locked_out !== 1'b1) begin errors++; $display("FAIL rs_lock valid=%0b out=%0d locked=%0b exp 1/112/1", taumin_valid_out, taumin_out, locked_out); end
        idle();
    endtask

    task automatic test_drop_to_acquire();
        for (int i = 0; i < 8; i++) send(500);
        checks++; if (locked_out !== 1'b0 || taumin_out !== 11'd112) begin errors++; $display("FAIL da_drop locked=%0b out=%0d exp 0/112", locked_out, taumin_out); end
        send(500);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL da_m2 valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(500);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd500 || locked_out !== 1'b1) begin errors++; $display("FAIL da_lock valid=%0b out=%0d locked=%0b exp 1/500/1", taumin_valid_out, taumin_out, locked_out); end
        idle();
    endtask

    task automatic test_range_edges();
        do_reset();
        send(19);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL re_19 valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(2047);
        send(2047);
        checks++; if (taumin_valid_out !== 1'b0) begin errors++; $display("FAIL re_hi2 valid=%0b exp 0", taumin_valid_out); end
        send(2047);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd2047 || locked_out !== 1'b1) begin errors++; $display("FAIL re_hilock valid=%0b out=%0d locked=%0b exp 1/2047/1", taumin_valid_out, taumin_out, locked_out); end
        send(2043);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd2043) begin errors++; $display("FAIL re_tol_dn valid=%0b out=%0d exp 1/2043", taumin_valid_out, taumin_out); end
        do_reset();
        send(20);
        send(24);
        send(20);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd20 || locked_out !== 1'b1) begin errors++; $display("FAIL re_lolock valid=%0b out=%0d locked=%0b exp 1/20/1", taumin_valid_out, taumin_out, locked_out); end
        send(25);
        checks++; if (taumin_valid_out !== 1'b0 || taumin_out !== 11'd20) begin errors++; $display("FAIL re_tol5 valid=%0b out=%0d exp 0/20", taumin_valid_out, taumin_out); end
        send(24);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd24) begin errors++; $display("FAIL re_tol4 valid=%0b out=%0d exp 1/24", taumin_valid_out, taumin_out); end
        idle();
    endtask

    task automatic test_async_reset();
        // Mid-cycle reset while locked clears outputs without a clock edge.
        #2 rst_in = 1'b0;
        #1;
        checks++; if (taumin_out !== 11'd0 || locked_out !== 1'b0) begin errors++; $display("FAIL ar_lock out=%0d locked=%0b exp 0/0", taumin_out, locked_out); end
        @(negedge clk_in);
        send(100);
        checks++; if (taumin_valid_out !== 1'b0 || taumin_out !== 11'd0) begin errors++; $display("FAIL ar_held valid=%0b out=%0d exp 0/0", taumin_valid_out, taumin_out); end
        taumin_valid_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clk_in);
        send(100);
        send(100);
        taumin_valid_in = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        checks++; if (taumin_out !== 11'd0 || taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL ar_acq out=%0d valid=%0b locked=%0b exp 0/0/0", taumin_out, taumin_valid_out, locked_out); end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        send(100);
        send(100);
        checks++; if (taumin_valid_out !== 1'b0 || locked_out !== 1'b0) begin errors++; $display("FAIL ar_nolock valid=%0b locked=%0b exp 0/0", taumin_valid_out, locked_out); end
        send(100);
        checks++; if (taumin_valid_out !== 1'b1 || taumin_out !== 11'd100 || locked_out !== 1'b1) begin errors++; $display("FAIL ar_relock valid=%0b out=%0d locked=%0b exp 1/100/1", taumin_valid_out, taumin_out, locked_out); end
        idle();
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_acquire();
        test_miss_recover();
        test_drop_unlocked();
        test_restart();
        test_drop_to_acquire();
        test_range_edges();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
